// File: rtl/mdu_div_ctrl_if.sv
// Handshake/bus bundle for mdu_div_ctrl: request side from the MDU issue path,
// result side toward the downstream FIFO.
interface mdu_div_ctrl_if #(
    parameter int unsigned ROB_ID_W = 6
);
    logic                valid_i;
    logic                ready_o;
    logic [31:0]         dividend_i;
    logic [31:0]         divisor_i;
    logic                signed_i;
    logic                rem_i;
    logic [ROB_ID_W-1:0] rob_id_i;
    logic                valid_o;
    logic                ready_i;
    logic [31:0]         data_o;
    logic [ROB_ID_W-1:0] rob_id_o;
    logic                busy_o;

    modport slave (
        input  valid_i, dividend_i, divisor_i, signed_i, rem_i, rob_id_i, ready_i,
        output ready_o, valid_o, data_o, rob_id_o, busy_o
    );

    modport master (
        output valid_i, dividend_i, divisor_i, signed_i, rem_i, rob_id_i, ready_i,
        input  ready_o, valid_o, data_o, rob_id_o, busy_o
    );
endinterface

// File: rtl/mdu_div_ctrl.sv
// Iterative 32-bit radix-2 restoring divider with IDLE/CALC/FIX/DONE sequencing.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips CALC and goes straight to FIX.
module mdu_div_ctrl #(
    parameter int unsigned ROB_ID_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    mdu_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [32:0]         rem_q,      rem_d;
    logic [31:0]         quo_q,      quo_d;
    logic [31:0]         dvs_q,      dvs_d;
    logic [31:0]         dvd_orig_q, dvd_orig_d;
    logic [4:0]          cnt_q,      cnt_d;
    logic                signed_q,   signed_d;
    logic                rem_sel_q,  rem_sel_d;
    logic                dvd_neg_q,  dvd_neg_d;
    logic                dvs_neg_q,  dvs_neg_d;
    logic                div_zero_q, div_zero_d;
    logic [ROB_ID_W-1:0] rob_id_q,   rob_id_d;
    logic [31:0]         data_q,     data_d;
    logic [ROB_ID_W-1:0] rob_out_q,  rob_out_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [33:0] rem_shift, rem_sub;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        a_neg = bus.signed_i & bus.dividend_i[31];
        b_neg = bus.signed_i & bus.divisor_i[31];
        a_mag = a_neg ? (~bus.dividend_i + 32'd1) : bus.dividend_i;
        b_mag = b_neg ? (~bus.divisor_i + 32'd1) : bus.divisor_i;

        // Extra top bit of rem_sub acts as the borrow of the trial subtraction.
        rem_shift = {1'b0, rem_q[31:0], quo_q[31]};
        rem_sub   = rem_shift - {2'b00, dvs_q};

        quo_fix = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? (~quo_q + 32'd1) : quo_q;
        rem_fix = (signed_q & dvd_neg_q) ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        if (div_zero_q) begin
            quo_fix = '1;
            rem_fix = dvd_orig_q;
        end

        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dvd_orig_d = dvd_orig_q;
        cnt_d      = cnt_q;
        signed_d   = signed_q;
        rem_sel_d  = rem_sel_q;
        dvd_neg_d  = dvd_neg_q;
        dvs_neg_d  = dvs_neg_q;
        div_zero_d = div_zero_q;
        rob_id_d   = rob_id_q;
        data_d     = data_q;
        rob_out_d  = rob_out_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_i && !flush) begin
                    quo_d      = a_mag;
                    dvs_d      = b_mag;
                    dvd_orig_d = bus.dividend_i;
                    signed_d   = bus.signed_i;
                    rem_sel_d  = bus.rem_i;
                    dvd_neg_d  = a_neg;
                    dvs_neg_d  = b_neg;
                    div_zero_d = (bus.divisor_i == '0);
                    rob_id_d   = bus.rob_id_i;
                    rem_d      = '0;
                    cnt_d      = '0;
`ifdef DIV_ZERO_BYPASS_EN
                    state_d    = (bus.divisor_i == '0) ? FIX : CALC;
`else
                    state_d    = CALC;
`endif
                end
            end
            CALC: begin
                if (!rem_sub[33]) begin
                    rem_d = rem_sub[32:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[32:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                data_d    = rem_sel_q ? rem_fix : quo_fix;
                rob_out_d = rob_id_q;
                state_d   = DONE;
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dvd_orig_q <= '0;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            rem_sel_q  <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rob_id_q   <= '0;
            data_q     <= '0;
            rob_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            dvd_orig_q <= dvd_orig_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            rem_sel_q  <= rem_sel_d;
            dvd_neg_q  <= dvd_neg_d;
            dvs_neg_q  <= dvs_neg_d;
            div_zero_q <= div_zero_d;
            rob_id_q   <= rob_id_d;
            data_q     <= data_d;
            rob_out_q  <= rob_out_d;
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.valid_o  = (state_q == DONE);
    assign bus.busy_o   = (state_q != IDLE);
    assign bus.data_o   = data_q;
    assign bus.rob_id_o = rob_out_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Bench for mdu_div_ctrl: directed vector table, hand-written backpressure/flush
// sequences, and random ops checked against an arithmetic reference model.
module tb_mdu_div_ctrl;

    localparam int unsigned RW = 6;

    logic clk;
    logic rst_n;
    logic flush;

    int total;
    int bad;

    mdu_div_ctrl_if #(.ROB_ID_W(RW)) bus ();

    mdu_div_ctrl #(.ROB_ID_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        r;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic r);
        logic [31:0] q, m;
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            m = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                m = 32'd0;
            end else begin
                q = sa / sb;
                m = sa % sb;
            end
        end else begin
            q = a / b;
            m = a % b;
        end
        return r ? m : q;
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
        return (b == 32'd0) ? 2 : 34;
`else
        if (b == 32'd0) return 34;
        return 34;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (bus.ready_o !== 1'b1) check("wait_ready_timeout", {31'd0, bus.ready_o}, 32'd1);
    endtask

    // Issue one op, wait for the result, consume it with a one-cycle ready_i.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic r, input logic [RW-1:0] id,
                         output logic [31:0] d, output logic [RW-1:0] rid, output int lat);
        wait_ready();
        bus.valid_i    = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.signed_i   = s;
        bus.rem_i      = r;
        bus.rob_id_i   = id;
        tick();
        bus.valid_i = 1'b0;
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        d   = bus.data_o;
        rid = bus.rob_id_o;
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0]   d, d0;
        logic [RW-1:0] rid, rid0;
        int            lat;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.valid_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.signed_i   = 1'b0;
        bus.rem_i      = 1'b0;
        bus.rob_id_i   = '0;
        bus.ready_i    = 1'b0;

        vecs.push_back('{32'd100,       32'd7,         1'b0, 1'b0, 32'h0000_000E});
        vecs.push_back('{32'd100,       32'd7,         1'b0, 1'b1, 32'h0000_0002});
        vecs.push_back('{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0, 32'hFFFF_FFFD});
        vecs.push_back('{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFF});
        vecs.push_back('{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD});
        vecs.push_back('{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0001});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000});
        vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 32'h1234_5678});
        vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5678});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF});

        repeat (3) tick();
        check("reset_ready_o",  {31'd0, bus.ready_o}, 32'd1);
        check("reset_valid_o",  {31'd0, bus.valid_o}, 32'd0);
        check("reset_busy_o",   {31'd0, bus.busy_o},  32'd0);
        check("reset_data_o",   bus.data_o, 32'd0);
        check("reset_rob_id_o", {26'd0, bus.rob_id_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            logic [RW-1:0] id;
            id = RW'(i + 1);
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, id, d, rid, lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            check($sformatf("vec%0d_rob_id", i), {26'd0, rid}, {26'd0, id});
            check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].b));
        end

        // Backpressure: hold result 10 cycles, then consume.
        wait_ready();
        bus.valid_i    = 1'b1;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd9;
        bus.signed_i   = 1'b0;
        bus.rem_i      = 1'b0;
        bus.rob_id_i   = 6'd42;
        tick();
        bus.valid_i = 1'b0;
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 34);
        d0   = bus.data_o;
        rid0 = bus.rob_id_o;
        check("bp_data", d0, 32'd111);
        check("bp_rob_id", {26'd0, rid0}, 32'd42);
        for (int unsigned k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_data", bus.data_o, d0);
            check("bp_hold_rob_id", {26'd0, bus.rob_id_o}, {26'd0, rid0});
            check("bp_hold_ready_o", {31'd0, bus.ready_o}, 32'd0);
            check("bp_hold_valid_o", {31'd0, bus.valid_o}, 32'd1);
        end
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        check("bp_release_ready_o", {31'd0, bus.ready_o}, 32'd1);
        check("bp_release_valid_o", {31'd0, bus.valid_o}, 32'd0);

        // Flush at CALC cycle 15 with a coincident request.
        wait_ready();
        bus.valid_i    = 1'b1;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd3;
        bus.signed_i   = 1'b0;
        bus.rem_i      = 1'b0;
        bus.rob_id_i   = 6'd5;
        tick();
        bus.valid_i = 1'b0;
        repeat (14) tick();
        check("flush_pre_busy", {31'd0, bus.busy_o}, 32'd1);
        flush          = 1'b1;
        bus.valid_i    = 1'b1;
        bus.dividend_i = 32'd50;
        bus.divisor_i  = 32'd5;
        bus.rob_id_i   = 6'd9;
        tick();
        flush       = 1'b0;
        bus.valid_i = 1'b0;
        check("flush_ready_o", {31'd0, bus.ready_o}, 32'd1);
        check("flush_valid_o", {31'd0, bus.valid_o}, 32'd0);
        check("flush_busy_o",  {31'd0, bus.busy_o},  32'd0);
        tick();
        check("flush_not_accepted", {31'd0, bus.ready_o}, 32'd1);
        do_op(32'd9, 32'd3, 1'b0, 1'b0, 6'd17, d, rid, lat);
        check("post_flush_data", d, 32'd3);
        check("post_flush_rob_id", {26'd0, rid}, 32'd17);
        check("post_flush_latency", lat, 34);

        // Random ops against the reference model.
        for (int unsigned i = 0; i < 40; i++) begin
            logic [31:0]   a, b;
            logic          s, r;
            logic [RW-1:0] id;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = ($urandom_range(0, 1) == 1) ? (32'd0 - 32'($urandom_range(1, 15)))
                                                   : 32'($urandom_range(1, 15));
                2: b = $urandom;
                default: b = 32'hFFFF_FFFF;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            s  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            id = RW'($urandom);
            do_op(a, b, s, r, id, d, rid, lat);
            check($sformatf("rnd%0d_data a=%h b=%h s=%0d r=%0d", i, a, b, s, r), d, model(a, b, s, r));
            check($sformatf("rnd%0d_rob_id", i), {26'd0, rid}, {26'd0, id});
            check($sformatf("rnd%0d_latency", i), lat, exp_lat(b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_div_ctrl.md
# mdu_div_ctrl

Iterative 32-bit divider with its sequencing FSM. It serves the division ops (DIV.W, DIV.WU, MOD.W, MOD.WU) that the MDU issue path sends to it, one at a time. It accepts a request through a valid/ready handshake and runs a radix-2 restoring shift-subtract over 32 cycles. It then fixes result signs and holds the result under a valid/ready handshake toward the downstream FIFO. `rob_id` travels alongside so the result can be written back onto the CDB.

## Interface
Parameters:
- ROB_ID_W, default 6: width of the rob id tag carried with each op.

Ports (reset rst_n is synchronous, active-low; clock is clk):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; kills any op in flight.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request (state IDLE).
- dividend_i  in  32  dividend.
- divisor_i  in  32  divisor.
- signed_i  in  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- rem_i  in  1  1 = return remainder (MOD), 0 = quotient (DIV).
- rob_id_i  in  ROB_ID_W  tag of the request.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- data_o  out  32  quotient or remainder.
- rob_id_o  out  ROB_ID_W  tag of the result.
- busy_o  out  1  state is not IDLE.

## Operation
- FSM states are IDLE, CALC, FIX and DONE. ready_o = (state==IDLE); valid_o = (state==DONE).
- **IDLE**: when valid_i is high and flush is low, latch operands, signed_i, rem_i and rob_id_i, then go to CALC.
  - Latched operands are magnitudes: negate an operand when signed_i is set and its bit 31 is 1.
  - Clear the 33-bit partial remainder and the 5-bit iteration counter.
- **CALC**: one iteration per cycle.
  - Shift {rem, quo} left by 1 and bring in the dividend MSB.
  - If rem ≥ divisor: rem −= divisor and set the quotient LSB.
  - The counter increments every cycle; at count 31, go to FIX. This gives exactly 32 CALC cycles.
- **FIX**: apply signs and select the output.
  - Quotient is negated if signed and the operand signs differ.
  - Remainder takes the dividend's sign.
  - data_o is the remainder if rem_i is set, otherwise the quotient. Register data_o and rob_id_o, then go to DONE.
- **Divide by zero** (forced in FIX regardless of signed_i): quotient = 0xFFFFFFFF, remainder = original dividend.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude algorithm and must not be special-cased incorrectly.
- **DONE**: hold data_o and rob_id_o stable while ready_i is low. On ready_i, go to IDLE. A new request is not accepted in the same cycle.
- **Flush**: in any state, the next state is IDLE and valid_o drops on the next cycle.
  - A valid_i that coincides with flush is not accepted.
  - A DONE result that is flushed while ready_i is high is treated as consumed; downstream ignores it because of the flush.
- **Reset** has the same effect as flush. Reset values: ready_o=1, valid_o=0, busy_o=0, data_o=0, rob_id_o=0, counter=0.

## Timing
- Let cycle 0 be the accept cycle (valid_i & ready_o).
  - CALC occupies cycles 1–32 and FIX occupies cycle 33.
  - valid_o is asserted from cycle 34.
- Minimum initiation interval is 35 cycles: 34 cycles to DONE, one DONE cycle with ready_i=1, then IDLE.
- The counter wraps from 31 to 0 only on the CALC→FIX transition.
- ready_o is combinational from the state register only. There is no combinational path from valid_i or ready_i to any output.

## Configuration
- DIV_ZERO_BYPASS_EN
  - When defined: if divisor_i==0 at accept, IDLE goes directly to FIX (CALC is skipped), so valid_o is asserted at cycle 2. The forced divide-by-zero results are unchanged.
  - When undefined: divide by zero runs the full 32 CALC cycles (valid_o at cycle 34) and produces the same forced results.

## Test plan
- Unsigned 100/7 with rem_i=0, then with rem_i=1 → data_o=14 (0x0000000E), then 2. In each run valid_o first asserts exactly 34 cycles after accept.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD (−3); MOD gives 0xFFFFFFFF (−1). Signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Overflow 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0x00000000.
- Divide 0x12345678 by 0, signed and unsigned → quotient 0xFFFFFFFF, remainder 0x12345678. valid_o arrives at cycle 2 with DIV_ZERO_BYPASS_EN defined, cycle 34 without.
- Backpressure: hold ready_i=0 for 10 cycles in DONE → data_o and rob_id_o are stable and ready_o=0. Then ready_i=1 for one cycle → IDLE and ready_o=1 on the next cycle.
- Flush at cycle 15 of CALC, with a new valid_i in the same cycle → not accepted. Next cycle: IDLE and ready_o=1. A subsequent 9/3 returns 3 with no corruption from the killed op.
